// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV64M multiply/divide unit for the EX stage.
// Multiply is shift-add, one multiplier bit per cycle. Divide is restoring
// division on magnitudes, one quotient bit per cycle. Signs are fixed up
// when the result is written.
// Optional feature macro: MULDIV_DIV_EN. When it is defined the divider and
// its DIV state are built. Without it, ops 4-7 go straight to DONE with a
// result of 0.
// Handshake: start is a valid-only strobe. It is accepted on an edge where the
// FSM is IDLE and flush is low. There is no ready signal. stall_req is the
// back-pressure: it freezes ID/EX, so start stays valid until it is taken.
// Starts seen while the unit is busy are ignored.
module ex_muldiv (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic        word_op,
    input  logic [63:0] src_a,
    input  logic [63:0] src_b,
    input  logic        flush,
    output logic        stall_req,
    output logic        busy,
    output logic        done,
    output logic [63:0] result,
    output logic [1:0]  dbg_state
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
`ifdef MULDIV_DIV_EN
        ST_DIV  = 2'd3,
`endif
        ST_DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [127:0] acc_q;      // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [63:0]  opnd_q;     // multiplicand or divisor magnitude
    logic [5:0]   cnt_q;
    logic [1:0]   op_q;
    logic         word_q;
    logic         neg_q;      // negate product / quotient
`ifdef MULDIV_DIV_EN
    logic         neg_r_q;    // remainder takes the dividend's sign
`endif

    logic         word_eff, signed_a, signed_b, a_neg, b_neg, iterating;
    logic [63:0]  a_ext, b_ext, a_mag, b_mag, final_res;
    logic [64:0]  mul_sum;
    logic [127:0] acc_step, prod_mag, prod;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Operand decode at capture: word extraction, sign extension, magnitudes.
    always_comb begin
        word_eff = word_op & ((op == 3'd0) | op[2]);
        signed_a = (op == 3'd0) | (op == 3'd1) | (op == 3'd2) | (op == 3'd4) | (op == 3'd6);
        signed_b = (op == 3'd0) | (op == 3'd1) | (op == 3'd4) | (op == 3'd6);
        a_ext    = src_a;
        b_ext    = src_b;
        if (word_eff) begin
            a_ext = {{32{signed_a & src_a[31]}}, src_a[31:0]};
            b_ext = {{32{signed_b & src_b[31]}}, src_b[31:0]};
        end
        a_neg = signed_a & a_ext[63];
        b_neg = signed_b & b_ext[63];
        a_mag = a_neg ? (~a_ext + 64'd1) : a_ext;
        b_mag = b_neg ? (~b_ext + 64'd1) : b_ext;
    end

`ifdef MULDIV_DIV_EN
    logic        div_special;
    logic [63:0] special_raw, special_res, div_min;
    logic [64:0] rem_sh, rem_sub;
    logic [63:0] quo, rem, div_sel;

    // Divide-by-zero and MIN/-1 skip iteration with a fixed answer.
    always_comb begin
        div_min     = word_eff ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
        div_special = 1'b0;
        special_raw = '1;
        if (b_ext == 64'd0) begin
            div_special = 1'b1;
            special_raw = op[1] ? a_ext : '1;
        end else if (signed_b && (a_ext == div_min) && (b_ext == '1)) begin
            div_special = 1'b1;
            special_raw = op[1] ? 64'd0 : a_ext;
        end
        special_res = word_eff ? sext32(special_raw[31:0]) : special_raw;
    end
`endif

    // One iteration step of whichever engine is running.
    always_comb begin
        mul_sum  = {1'b0, acc_q[127:64]} + (acc_q[0] ? {1'b0, opnd_q} : 65'd0);
        acc_step = {mul_sum, acc_q[63:1]};
        iterating = (state_q == ST_MUL);
`ifdef MULDIV_DIV_EN
        rem_sh  = {acc_q[127:64], acc_q[63]};
        rem_sub = rem_sh - {1'b0, opnd_q};
        if (state_q == ST_DIV) begin
            iterating = 1'b1;
            acc_step  = {(rem_sub[64] ? rem_sh[63:0] : rem_sub[63:0]), acc_q[62:0], ~rem_sub[64]};
        end
`endif
    end

    // Sign fix-up and selection of the value written on the last step.
    always_comb begin
        prod_mag = word_q ? {64'd0, acc_step[95:32]} : acc_step;
        prod     = neg_q ? (~prod_mag + 128'd1) : prod_mag;
        if (op_q == 2'd0) final_res = word_q ? sext32(prod[31:0]) : prod[63:0];
        else              final_res = prod[127:64];
`ifdef MULDIV_DIV_EN
        quo     = neg_q   ? (~acc_step[63:0] + 64'd1)   : acc_step[63:0];
        rem     = neg_r_q ? (~acc_step[127:64] + 64'd1) : acc_step[127:64];
        div_sel = op_q[1] ? rem : quo;
        if (state_q == ST_DIV) final_res = word_q ? sext32(div_sel[31:0]) : div_sel;
`endif
    end

    // State register.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; flush always wins.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (!op[2])           state_d = ST_MUL;
`ifdef MULDIV_DIV_EN
                    else if (div_special) state_d = ST_DONE;
                    else                  state_d = ST_DIV;
`else
                    else                  state_d = ST_DONE;
`endif
                end
            end
            ST_MUL:  if (cnt_q == 6'd0) state_d = ST_DONE;
`ifdef MULDIV_DIV_EN
            ST_DIV:  if (cnt_q == 6'd0) state_d = ST_DONE;
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    // Datapath: capture in IDLE, iterate in MUL/DIV, write result on the last step.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            acc_q   <= '0;
            opnd_q  <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            word_q  <= 1'b0;
            neg_q   <= 1'b0;
            result  <= '0;
`ifdef MULDIV_DIV_EN
            neg_r_q <= 1'b0;
`endif
        end else if (!flush) begin
            if ((state_q == ST_IDLE) && start) begin
                op_q   <= op[1:0];
                word_q <= word_eff;
                neg_q  <= a_neg ^ b_neg;
                cnt_q  <= word_eff ? 6'd31 : 6'd63;
                if (!op[2]) begin
                    opnd_q <= a_mag;
                    acc_q  <= {64'd0, b_mag};
                end else begin
`ifdef MULDIV_DIV_EN
                    opnd_q  <= b_mag;
                    acc_q   <= {64'd0, (word_eff ? {a_mag[31:0], 32'd0} : a_mag)};
                    neg_r_q <= a_neg;
                    if (div_special) result <= special_res;
`else
                    result <= 64'd0;
`endif
                end
            end else if (iterating) begin
                acc_q <= acc_step;
                cnt_q <= cnt_q - 6'd1;
                if (cnt_q == 6'd0) result <= final_res;
            end
        end
    end

    // Status outputs decoded from the state.
    always_comb begin
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_DONE);
        stall_req = iterating | ((state_q == ST_IDLE) & start & sys_rst);
        dbg_state = state_q;
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed bench for ex_muldiv with an arithmetic reference
// model, a per-cycle compare process and hand-computed literal results.
`timescale 1ns/1ps
module tb_ex_muldiv;
`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic        word_op = 1'b0;
    logic [63:0] src_a = 64'd0;
    logic [63:0] src_b = 64'd0;
    logic        flush = 1'b0;
    logic        stall_req, busy, done;
    logic [63:0] result;
    logic [1:0]  dbg_state;

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q[$];
    int          lat_q[$];

    ex_muldiv dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .op(op),
        .word_op(word_op), .src_a(src_a), .src_b(src_b), .flush(flush),
        .stall_req(stall_req), .busy(busy), .done(done), .result(result),
        .dbg_state(dbg_state)
    );

    // Clock.
    always #5 sys_clk = ~sys_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Reference model: plain arithmetic from the op definitions.
    function automatic logic [63:0] model(input logic [2:0] o, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
        logic [127:0]       p;
        logic signed [63:0] sa, sb, sq;
        logic signed [31:0] sa32, sb32, sq32;
        logic [31:0]        ua32, ub32;
        logic [63:0]        r;
        sa = a; sb = b; sa32 = a[31:0]; sb32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
        r = 64'd0;
        if (o[2] && !DIV_EN) return 64'd0;
        case (o)
            3'd0: begin r = a * b; if (w) r = sx32(r[31:0]); end
            3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
            3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b};       r = p[127:64]; end
            3'd3: begin p = {64'd0, a} * {64'd0, b};             r = p[127:64]; end
            3'd4, 3'd6: begin
                if (w) begin
                    if (ub32 == 32'd0)                                   r = (o == 3'd6) ? sx32(ua32) : ONES;
                    else if (ua32 == 32'h8000_0000 && ub32 == 32'hFFFF_FFFF) r = (o == 3'd6) ? 64'd0 : sx32(ua32);
                    else begin
                        sq32 = (o == 3'd6) ? (sa32 % sb32) : (sa32 / sb32);
                        r = sx32(sq32);
                    end
                end else begin
                    if (b == 64'd0)                                      r = (o == 3'd6) ? a : ONES;
                    else if (a == 64'h8000_0000_0000_0000 && b == ONES)  r = (o == 3'd6) ? 64'd0 : a;
                    else begin
                        sq = (o == 3'd6) ? (sa % sb) : (sa / sb);
                        r = sq;
                    end
                end
            end
            default: begin
                if (w) begin
                    if (ub32 == 32'd0) r = (o == 3'd7) ? sx32(ua32) : ONES;
                    else               r = sx32((o == 3'd7) ? (ua32 % ub32) : (ua32 / ub32));
                end else begin
                    if (b == 64'd0) r = (o == 3'd7) ? a : ONES;
                    else            r = (o == 3'd7) ? (a % b) : (a / b);
                end
            end
        endcase
        return r;
    endfunction

    // Edges from capture (inclusive) to the done cycle.
    function automatic int lat_of(input logic [2:0] o, input logic w,
                                  input logic [63:0] a, input logic [63:0] b);
        logic zero, ovf;
        if (!o[2]) return (w && o == 3'd0) ? 33 : 65;
        if (!DIV_EN) return 1;
        zero = w ? (b[31:0] == 32'd0) : (b == 64'd0);
        ovf  = ((o == 3'd4) || (o == 3'd6)) &&
               (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                  : (a == 64'h8000_0000_0000_0000 && b == ONES));
        if (zero || ovf) return 1;
        return w ? 33 : 65;
    endfunction

    function automatic logic [63:0] dv(input logic [63:0] v);
        return DIV_EN ? v : 64'd0;
    endfunction

    function automatic int dl(input int l);
        return DIV_EN ? l : 1;
    endfunction

    // Compare process: every cycle, outputs against the tracked expectation.
    bit          trk_busy = 1'b0;
    int          trk_k = 0;
    int          trk_lat = 0;
    logic [63:0] trk_exp = 64'd0;
    logic [63:0] held = 64'd0;

    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            trk_busy = 1'b0;
            held = 64'd0;
        end else begin
            if (trk_busy) begin
                chk64("mon busy", {63'd0, busy}, 64'd1);
                chk64("mon done", {63'd0, done}, {63'd0, trk_k == trk_lat});
                chk64("mon stall_req", {63'd0, stall_req}, {63'd0, trk_k < trk_lat});
                chk64("mon result", result, (trk_k == trk_lat) ? trk_exp : held);
            end else begin
                chk64("mon idle busy", {63'd0, busy}, 64'd0);
                chk64("mon idle done", {63'd0, done}, 64'd0);
                chk64("mon idle stall_req", {63'd0, stall_req}, {63'd0, start});
                chk64("mon idle result", result, held);
            end
            if (trk_busy && trk_k == trk_lat) held = trk_exp;
            if (flush) trk_busy = 1'b0;
            else if (trk_busy) begin
                if (trk_k == trk_lat) trk_busy = 1'b0;
                else trk_k++;
            end else if (start) begin
                if (exp_q.size() == 0 || lat_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL mon scoreboard: start accepted with empty expected queue");
                end else begin
                    trk_exp = exp_q.pop_front();
                    trk_lat = lat_q.pop_front();
                    trk_busy = 1'b1;
                    trk_k = 1;
                end
            end
        end
    end

    // Driver: issue one op, wait (bounded) for done, check result and latency.
    task automatic run_op(input string name, input logic [2:0] o, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input bit has_lit, input logic [63:0] lit, input int lit_lat);
        logic [63:0] mexp;
        int mlat, edges;
        mexp = model(o, w, a, b);
        mlat = lat_of(o, w, a, b);
        exp_q.push_back(mexp);
        lat_q.push_back(mlat);
        @(posedge sys_clk); #1;
        start = 1'b1; op = o; word_op = w; src_a = a; src_b = b;
        @(posedge sys_clk); #1;
        start = 1'b0;
        edges = 1;
        while (done !== 1'b1 && edges < 200) begin
            @(posedge sys_clk); #1;
            edges++;
        end
        if (done !== 1'b1) begin
            checks++; failures++;
            $display("FAIL %s timeout: no done after %0d edges", name, edges);
        end else begin
            chk64({name, " result"}, result, has_lit ? lit : mexp);
            chk64({name, " latency"}, 64'(edges), 64'(has_lit ? lit_lat : mlat));
        end
    endtask

    initial begin
        int edges, pulses;
        // Reset state.
        #1 sys_rst = 1'b0;
        #2;
        chk64("reset busy", {63'd0, busy}, 64'd0);
        chk64("reset done", {63'd0, done}, 64'd0);
        chk64("reset stall_req", {63'd0, stall_req}, 64'd0);
        chk64("reset result", result, 64'd0);
        repeat (3) @(posedge sys_clk);
        #3 sys_rst = 1'b1;

        // Multiply family.
        run_op("MUL 3*-5", 3'd0, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 1, 64'hFFFF_FFFF_FFFF_FFF1, 65);
        run_op("MULHU max", 3'd3, 1'b0, ONES, ONES, 1, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        run_op("MULH min*min", 3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1, 64'h4000_0000_0000_0000, 65);
        run_op("MULHSU -1*2", 3'd2, 1'b0, ONES, 64'd2, 1, ONES, 65);
        run_op("MULW 2^30*2", 3'd0, 1'b1, 64'h4000_0000, 64'd2, 1, 64'hFFFF_FFFF_8000_0000, 33);
        run_op("MULW hi ignored", 3'd0, 1'b1, 64'hFFFF_FFFF_0000_0003, 64'd7, 1, 64'h15, 33);
        run_op("MULHU word ignored", 3'd3, 1'b1, ONES, ONES, 1, 64'hFFFF_FFFF_FFFF_FFFE, 65);

        // Divide family (constant 0 / 1 edge when the divider is not built).
        run_op("DIV 7/0", 3'd4, 1'b0, 64'd7, 64'd0, 1, dv(ONES), 1);
        run_op("REM 7/0", 3'd6, 1'b0, 64'd7, 64'd0, 1, dv(64'd7), 1);
        run_op("DIVW min/-1", 3'd4, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 1, dv(64'hFFFF_FFFF_8000_0000), 1);
        run_op("REMW -7/2", 3'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1, dv(ONES), dl(33));
        run_op("DIV -20/3", 3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 1, dv(64'hFFFF_FFFF_FFFF_FFFA), dl(65));
        run_op("REM -20/3", 3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 1, dv(64'hFFFF_FFFF_FFFF_FFFE), dl(65));
        run_op("DIVU 100/7", 3'd5, 1'b0, 64'd100, 64'd7, 1, dv(64'd14), dl(65));
        run_op("REMU 100/7", 3'd7, 1'b0, 64'd100, 64'd7, 1, dv(64'd2), dl(65));
        run_op("DIV min/-1", 3'd4, 1'b0, 64'h8000_0000_0000_0000, ONES, 1, dv(64'h8000_0000_0000_0000), 1);
        run_op("REM min/-1", 3'd6, 1'b0, 64'h8000_0000_0000_0000, ONES, 1, 64'd0, 1);
        run_op("DIVUW ffffffff/2", 3'd5, 1'b1, 64'hFFFF_FFFF, 64'd2, 1, dv(64'h7FFF_FFFF), dl(33));
        run_op("REMUW 80000005/16", 3'd7, 1'b1, 64'h8000_0005, 64'h10, 1, dv(64'd5), dl(33));
        run_op("DIVW 20/-3", 3'd4, 1'b1, 64'd20, 64'hFFFF_FFFD, 1, dv(64'hFFFF_FFFF_FFFF_FFFA), dl(33));

        // Flush at iteration 10: no done, result unchanged.
        run_op("MUL pre-flush", 3'd0, 1'b0, 64'd6, 64'd7, 1, 64'd42, 65);
        exp_q.push_back(model(3'd0, 1'b0, 64'd9, 64'd9));
        lat_q.push_back(65);
        @(posedge sys_clk); #1;
        start = 1'b1; op = 3'd0; word_op = 1'b0; src_a = 64'd9; src_b = 64'd9;
        @(posedge sys_clk); #1;
        start = 1'b0;
        repeat (8) @(posedge sys_clk);
        #1 flush = 1'b1;
        @(posedge sys_clk); #1;
        flush = 1'b0;
        chk64("flush busy", {63'd0, busy}, 64'd0);
        chk64("flush stall_req", {63'd0, stall_req}, 64'd0);
        pulses = 0;
        repeat (70) begin
            @(posedge sys_clk); #1;
            if (done === 1'b1) pulses++;
        end
        chk64("flush done pulses", 64'(pulses), 64'd0);
        chk64("flush result held", result, 64'd42);

        // start together with flush in IDLE is not accepted.
        @(posedge sys_clk); #1;
        start = 1'b1; flush = 1'b1; op = 3'd0; src_a = 64'd5; src_b = 64'd5;
        @(posedge sys_clk); #1;
        start = 1'b0; flush = 1'b0;
        chk64("start+flush busy", {63'd0, busy}, 64'd0);

        // start while busy is ignored.
        exp_q.push_back(model(3'd3, 1'b0, 64'h1_0000_0000, 64'h1_0000_0000));
        lat_q.push_back(65);
        @(posedge sys_clk); #1;
        start = 1'b1; op = 3'd3; word_op = 1'b0; src_a = 64'h1_0000_0000; src_b = 64'h1_0000_0000;
        @(posedge sys_clk); #1;
        start = 1'b0;
        edges = 1;
        repeat (5) begin @(posedge sys_clk); #1; edges++; end
        start = 1'b1; op = 3'd4; src_a = 64'd7; src_b = 64'd0;
        repeat (3) begin @(posedge sys_clk); #1; edges++; end
        start = 1'b0;
        while (done !== 1'b1 && edges < 200) begin @(posedge sys_clk); #1; edges++; end
        chk64("busy-start result", result, 64'd1);
        chk64("busy-start latency", 64'(edges), 64'd65);

        // Asynchronous reset in the middle of an op.
        run_op("DIVU pre-reset", 3'd5, 1'b0, 64'd50, 64'd5, 1, dv(64'd10), dl(65));
        exp_q.push_back(model(DIV_EN ? 3'd4 : 3'd0, 1'b0, 64'd1000, 64'd3));
        lat_q.push_back(65);
        @(posedge sys_clk); #1;
        start = 1'b1; op = DIV_EN ? 3'd4 : 3'd0; word_op = 1'b0; src_a = 64'd1000; src_b = 64'd3;
        @(posedge sys_clk); #1;
        start = 1'b0;
        repeat (20) @(posedge sys_clk);
        #3 sys_rst = 1'b0;
        #1;
        chk64("mid-op reset busy", {63'd0, busy}, 64'd0);
        chk64("mid-op reset done", {63'd0, done}, 64'd0);
        chk64("mid-op reset stall_req", {63'd0, stall_req}, 64'd0);
        chk64("mid-op reset result", result, 64'd0);
        repeat (2) @(posedge sys_clk);
        #3 sys_rst = 1'b1;
        run_op("MUL post-reset", 3'd0, 1'b0, 64'd11, 64'd13, 1, 64'd143, 65);

        // Random operands against the model.
        for (int i = 0; i < 10; i++) begin
            run_op("rand", 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   {$urandom, $urandom}, {32'($urandom_range(0, 3)) * 32'hFFFF_FFFF, $urandom},
                   0, 64'd0, 0);
        end

        @(posedge sys_clk); #1;
        chk64("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
